// File: rtl/pfq_pkg.sv
// Shared definitions for the prefetch queue: fetch FSM states, bus-width constants
// and the per-fetch byte count helper.
package pfq_pkg;

  typedef enum logic [1:0] {
    FS_IDLE    = 2'd0,
    FS_REQ     = 2'd1,
    FS_WAIT    = 2'd2,
    FS_DISCARD = 2'd3
  } fetch_state_t;

  localparam int BUS_BYTES_8088 = 1;
  localparam int BUS_BYTES_8086 = 2;

  function automatic logic bus_bytes_legal(input int bus_bytes);
    return (bus_bytes == BUS_BYTES_8088) || (bus_bytes == BUS_BYTES_8086);
  endfunction

  // An odd fetch pointer on a 16-bit bus can only pull the upper byte of the word.
  function automatic logic [1:0] calc_nbytes(input int bus_bytes, input logic fp0);
    if (bus_bytes == BUS_BYTES_8086 && !fp0) return 2'd2;
    return 2'd1;
  endfunction

endpackage

// File: rtl/pfq_store.sv
// DEPTH-byte circular buffer: 1- or 2-byte write port, 1-byte combinational read port.
// Write-then-read latency is one cycle; i_clear empties it and wins over read and write.
module pfq_store #(
  parameter int DEPTH = 4,
  parameter int LW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_clear,
  input  logic          i_wr_en,
  input  logic          i_wr_two,
  input  logic [15:0]   i_wr_dat,
  input  logic          i_rd_en,
  output logic [7:0]    o_rd_dat,
  output logic [LW-1:0] o_count,
  output logic          o_empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [7:0]    r_mem [DEPTH];
  logic [PW-1:0] r_rd_ptr;
  logic [PW-1:0] r_wr_ptr;
  logic [LW-1:0] r_count;

  logic [PW-1:0] w_wr_ptr1;
  logic [LW-1:0] w_add;
  logic [LW-1:0] w_sub;
  logic          w_pop;

  // DEPTH need not be a power of two, so pointers wrap explicitly.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign w_wr_ptr1 = ptr_inc(r_wr_ptr);
  assign w_pop     = i_rd_en && (r_count != '0);
  assign w_add     = i_wr_en ? (i_wr_two ? LW'(2) : LW'(1)) : '0;
  assign w_sub     = w_pop ? LW'(1) : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (i_clear) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_wr_en) begin
        r_mem[r_wr_ptr] <= i_wr_dat[7:0];
        if (i_wr_two) r_mem[w_wr_ptr1] <= i_wr_dat[15:8];
        r_wr_ptr <= i_wr_two ? ptr_inc(w_wr_ptr1) : w_wr_ptr1;
      end
      if (w_pop) r_rd_ptr <= ptr_inc(r_rd_ptr);
      r_count <= r_count + w_add - w_sub;
    end
  end

  assign o_rd_dat = r_mem[r_rd_ptr];
  assign o_count  = r_count;
  assign o_empty  = (r_count == '0);

endmodule

// File: rtl/prefetch_queue_gen.sv
// 8088/8086 instruction prefetch queue: fetch FSM, fetch pointer, head offset and flush.
// Fill data visible one cycle after FILL_VALID; fetches issue only when the whole fill fits.
module prefetch_queue_gen
  import pfq_pkg::*;
#(
  parameter int BUS_BYTES = 1,
  parameter int DEPTH     = 4,
  parameter int LW        = $clog2(DEPTH + 1)
) (
  input  logic                   CORE_CLK,
  input  logic                   RESET,
  input  logic                   FLUSH,
  input  logic [15:0]            FLUSH_ADDR,
  input  logic                   SUSPEND,
  output logic                   FETCH_REQ,
  output logic [15:0]            FETCH_ADDR,
  output logic                   FETCH_ODD,
  input  logic                   FETCH_ACK,
  input  logic                   FILL_VALID,
  input  logic [8*BUS_BYTES-1:0] FILL_DATA,
  input  logic                   POP,
  output logic [7:0]             TOP_BYTE,
  output logic [15:0]            ADDR_OUT,
  output logic                   EMPTY,
  output logic [LW-1:0]          LEVEL
);

  // Unsupported bus widths fall back to 8088 behaviour.
  localparam int BB = bus_bytes_legal(BUS_BYTES) ? BUS_BYTES : BUS_BYTES_8088;
  localparam int CW = LW + 1;

  fetch_state_t r_state;
  fetch_state_t w_state_nxt;
  logic [15:0]  r_fp;
  logic [15:0]  r_addr_out;
  logic [15:0]  r_fetch_addr;
  logic         r_fetch_odd;
  logic [1:0]   r_nbytes;

  logic [1:0]    w_nbytes;
  logic          w_space;
  logic          w_start;
  logic          w_wr_en;
  logic          w_pop;
  logic [15:0]   w_wr_dat;
  logic [LW-1:0] w_level;
  logic          w_empty;
  logic [7:0]    w_top;

  assign w_nbytes = calc_nbytes(BB, r_fp[0]);
  assign w_space  = (CW'(w_level) + CW'(w_nbytes)) <= CW'(DEPTH);
  assign w_start  = (r_state == FS_IDLE) && !SUSPEND && !FLUSH && w_space;
  assign w_wr_en  = (r_state == FS_WAIT) && FILL_VALID && !FLUSH;
  assign w_pop    = POP && !w_empty && !FLUSH;

  // An odd fill carries its only valid byte in the upper lane.
  generate
    if (BB == 2) begin : g_bus16
      assign w_wr_dat = r_fetch_odd ? {8'h00, FILL_DATA[15:8]} : FILL_DATA[15:0];
    end else begin : g_bus8
      assign w_wr_dat = {8'h00, FILL_DATA[7:0]};
    end
  endgenerate

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      FS_IDLE: begin
        if (w_start) w_state_nxt = FS_REQ;
      end
      FS_REQ: begin
        if (FLUSH)          w_state_nxt = FETCH_ACK ? FS_DISCARD : FS_IDLE;
        else if (FETCH_ACK) w_state_nxt = FS_WAIT;
      end
      FS_WAIT: begin
        if (FLUSH)           w_state_nxt = FILL_VALID ? FS_IDLE : FS_DISCARD;
        else if (FILL_VALID) w_state_nxt = FS_IDLE;
      end
      FS_DISCARD: begin
        if (!FLUSH && FILL_VALID) w_state_nxt = FS_IDLE;
      end
      default: w_state_nxt = FS_IDLE;
    endcase
  end

  always_ff @(posedge CORE_CLK or posedge RESET) begin
    if (RESET) begin
      r_state      <= FS_IDLE;
      r_fp         <= '0;
      r_addr_out   <= '0;
      r_fetch_addr <= '0;
      r_fetch_odd  <= 1'b0;
      r_nbytes     <= 2'd1;
    end else begin
      r_state <= w_state_nxt;
      // Address, odd flag and size stay frozen for the whole REQ/WAIT episode.
      if (w_start) begin
        r_fetch_addr <= (BB == 2) ? {r_fp[15:1], 1'b0} : r_fp;
        r_fetch_odd  <= (BB == 2) && r_fp[0];
        r_nbytes     <= w_nbytes;
      end
      if (FLUSH) begin
        r_fp       <= FLUSH_ADDR;
        r_addr_out <= FLUSH_ADDR;
      end else begin
        if (w_wr_en) r_fp <= r_fp + {14'd0, r_nbytes};
        if (w_pop)   r_addr_out <= r_addr_out + 16'd1;
      end
    end
  end

  pfq_store #(
    .DEPTH (DEPTH),
    .LW    (LW)
  ) u_store (
    .clk      (CORE_CLK),
    .rst      (RESET),
    .i_clear  (FLUSH),
    .i_wr_en  (w_wr_en),
    .i_wr_two (r_nbytes == 2'd2),
    .i_wr_dat (w_wr_dat),
    .i_rd_en  (w_pop),
    .o_rd_dat (w_top),
    .o_count  (w_level),
    .o_empty  (w_empty)
  );

  assign FETCH_REQ  = (r_state == FS_REQ);
  assign FETCH_ADDR = r_fetch_addr;
  assign FETCH_ODD  = r_fetch_odd;
  assign TOP_BYTE   = w_top;
  assign ADDR_OUT   = r_addr_out;
  assign EMPTY      = w_empty;
  assign LEVEL      = w_level;

endmodule

// File: tb/tb_prefetch_queue_gen.sv
// Bench for prefetch_queue_gen in 8088 mode (BUS_BYTES=1, DEPTH=4) and 8086 mode (BUS_BYTES=2, DEPTH=6).
// Expected fetches and popped bytes are queued by the stimulus and checked by negedge monitors.
module tb_prefetch_queue_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic        a_flush, a_susp, a_ack, a_fill, a_pop;
  logic [15:0] a_flush_addr;
  logic [7:0]  a_fdat;
  logic        a_req, a_odd, a_empty;
  logic [15:0] a_faddr, a_addr;
  logic [7:0]  a_top;
  logic [2:0]  a_level;

  logic        b_flush, b_susp, b_ack, b_fill, b_pop;
  logic [15:0] b_flush_addr;
  logic [15:0] b_fdat;
  logic        b_req, b_odd, b_empty;
  logic [15:0] b_faddr, b_addr;
  logic [7:0]  b_top;
  logic [2:0]  b_level;

  int n_checks = 0;
  int n_pass   = 0;

  logic [16:0] a_fq[$];
  logic [16:0] b_fq[$];
  logic [23:0] a_bq[$];
  logic [23:0] b_bq[$];

  prefetch_queue_gen #(.BUS_BYTES(1), .DEPTH(4)) u_dut_a (
    .CORE_CLK(clk), .RESET(rst), .FLUSH(a_flush), .FLUSH_ADDR(a_flush_addr), .SUSPEND(a_susp),
    .FETCH_REQ(a_req), .FETCH_ADDR(a_faddr), .FETCH_ODD(a_odd), .FETCH_ACK(a_ack),
    .FILL_VALID(a_fill), .FILL_DATA(a_fdat), .POP(a_pop), .TOP_BYTE(a_top),
    .ADDR_OUT(a_addr), .EMPTY(a_empty), .LEVEL(a_level)
  );

  prefetch_queue_gen #(.BUS_BYTES(2), .DEPTH(6)) u_dut_b (
    .CORE_CLK(clk), .RESET(rst), .FLUSH(b_flush), .FLUSH_ADDR(b_flush_addr), .SUSPEND(b_susp),
    .FETCH_REQ(b_req), .FETCH_ADDR(b_faddr), .FETCH_ODD(b_odd), .FETCH_ACK(b_ack),
    .FILL_VALID(b_fill), .FILL_DATA(b_fdat), .POP(b_pop), .TOP_BYTE(b_top),
    .ADDR_OUT(b_addr), .EMPTY(b_empty), .LEVEL(b_level)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, required %h", name, act, exp);
  endtask

  logic a_req_d = 1'b0;
  logic b_req_d = 1'b0;

  always @(negedge clk) begin : mon_a
    logic [16:0] ef;
    logic [23:0] eb;
    if (a_req && !a_req_d) begin
      if (a_fq.size() == 0) begin
        n_checks++;
        $display("FAIL a_fetch_unexpected: got addr %h, required no request", a_faddr);
      end else begin
        ef = a_fq.pop_front();
        chk("a_fetch", 32'({a_odd, a_faddr}), 32'(ef));
      end
    end
    a_req_d = a_req;
    if (a_pop && !a_empty) begin
      if (a_bq.size() == 0) begin
        n_checks++;
        $display("FAIL a_pop_unexpected: got byte %h at %h, required no pop", a_top, a_addr);
      end else begin
        eb = a_bq.pop_front();
        chk("a_pop_byte", 32'({a_top, a_addr}), 32'(eb));
      end
    end
  end

  always @(negedge clk) begin : mon_b
    logic [16:0] ef;
    logic [23:0] eb;
    if (b_req && !b_req_d) begin
      if (b_fq.size() == 0) begin
        n_checks++;
        $display("FAIL b_fetch_unexpected: got addr %h, required no request", b_faddr);
      end else begin
        ef = b_fq.pop_front();
        chk("b_fetch", 32'({b_odd, b_faddr}), 32'(ef));
      end
    end
    b_req_d = b_req;
    if (b_pop && !b_empty) begin
      if (b_bq.size() == 0) begin
        n_checks++;
        $display("FAIL b_pop_unexpected: got byte %h at %h, required no pop", b_top, b_addr);
      end else begin
        eb = b_bq.pop_front();
        chk("b_pop_byte", 32'({b_top, b_addr}), 32'(eb));
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic a_wait_req();
    int n = 0;
    while (!a_req && n < 40) begin
      tick(1);
      n++;
    end
    chk("a_req_seen", 32'(a_req), 1);
  endtask

  task automatic b_wait_req();
    int n = 0;
    while (!b_req && n < 40) begin
      tick(1);
      n++;
    end
    chk("b_req_seen", 32'(b_req), 1);
  endtask

  task automatic a_serve(input logic [7:0] d);
    a_wait_req();
    a_ack = 1'b1;
    tick(1);
    a_ack  = 1'b0;
    a_fill = 1'b1;
    a_fdat = d;
    tick(1);
    a_fill = 1'b0;
  endtask

  task automatic b_serve(input logic [15:0] d, input logic p, input logic s);
    b_wait_req();
    b_ack = 1'b1;
    tick(1);
    b_ack  = 1'b0;
    b_fill = 1'b1;
    b_fdat = d;
    b_pop  = p;
    b_susp = s;
    tick(1);
    b_fill = 1'b0;
    b_pop  = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: run did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    a_flush = 0; a_susp = 0; a_ack = 0; a_fill = 0; a_pop = 0; a_flush_addr = '0; a_fdat = '0;
    b_flush = 0; b_susp = 1; b_ack = 0; b_fill = 0; b_pop = 0; b_flush_addr = '0; b_fdat = '0;
    tick(2);

    chk("rst_a_req",   32'(a_req), 0);
    chk("rst_a_faddr", 32'(a_faddr), 0);
    chk("rst_a_empty", 32'(a_empty), 1);
    chk("rst_a_level", 32'(a_level), 0);
    chk("rst_a_top",   32'(a_top), 0);
    chk("rst_a_addr",  32'(a_addr), 0);
    chk("rst_b_odd",   32'(b_odd), 0);
    chk("rst_b_faddr", 32'(b_faddr), 0);

    // 8088: fill to capacity from 0x0000
    for (int i = 0; i < 4; i++) a_fq.push_back(17'(i));
    rst = 1'b0;
    for (int i = 0; i < 4; i++) a_serve(8'(8'h10 + i));
    chk("a_full_level", 32'(a_level), 4);
    chk("a_full_top",   32'(a_top), 32'h10);
    chk("a_full_addr",  32'(a_addr), 0);
    tick(4);
    chk("a_full_noreq", 32'(a_req), 0);

    a_fq.push_back(17'h00004);
    a_bq.push_back({8'h10, 16'h0000});
    a_pop = 1'b1;
    tick(1);
    a_pop = 1'b0;
    chk("a_pop_level", 32'(a_level), 3);
    chk("a_pop_top",   32'(a_top), 32'h11);
    chk("a_pop_addr",  32'(a_addr), 32'h0001);
    a_serve(8'h14);
    chk("a_refill_level", 32'(a_level), 4);

    // Flush while WAIT: the in-flight fill is dropped
    a_bq.push_back({8'h11, 16'h0001});
    a_pop = 1'b1;
    tick(1);
    a_pop = 1'b0;
    a_fq.push_back(17'h00005);
    a_wait_req();
    a_ack = 1'b1;
    tick(1);
    a_ack = 1'b0;
    a_flush = 1'b1;
    a_flush_addr = 16'h2000;
    tick(1);
    a_flush = 1'b0;
    chk("a_flush_level", 32'(a_level), 0);
    chk("a_flush_empty", 32'(a_empty), 1);
    chk("a_flush_addr",  32'(a_addr), 32'h2000);
    a_fq.push_back(17'h02000);
    a_fill = 1'b1;
    a_fdat = 8'hEE;
    tick(1);
    a_fill = 1'b0;
    chk("a_discard_level", 32'(a_level), 0);
    chk("a_discard_empty", 32'(a_empty), 1);

    // Flush while REQ without ACK, then wrap past 0xFFFF
    a_wait_req();
    a_flush = 1'b1;
    a_flush_addr = 16'hFFFF;
    tick(1);
    a_flush = 1'b0;
    chk("a_flush_req_drop", 32'(a_req), 0);
    chk("a_wrap_addr0",     32'(a_addr), 32'hFFFF);
    a_fq.push_back(17'h0FFFF);
    a_fq.push_back(17'h00000);
    a_serve(8'hA1);
    a_serve(8'hA2);
    a_susp = 1'b1;
    chk("a_wrap_level", 32'(a_level), 2);
    chk("a_wrap_top",   32'(a_top), 32'hA1);
    chk("a_wrap_faddr", 32'(a_faddr), 0);
    a_bq.push_back({8'hA1, 16'hFFFF});
    a_bq.push_back({8'hA2, 16'h0000});
    a_pop = 1'b1;
    tick(2);
    a_pop = 1'b0;
    chk("a_wrap_addr2", 32'(a_addr), 32'h0001);
    chk("a_wrap_empty", 32'(a_empty), 1);

    // Asynchronous reset in the middle of WAIT
    a_susp = 1'b0;
    a_fq.push_back(17'h00001);
    a_wait_req();
    a_ack = 1'b1;
    tick(1);
    a_ack = 1'b0;
    chk("a_wait_faddr", 32'(a_faddr), 32'h0001);
    rst = 1'b1;
    #2;
    chk("arst_req",   32'(a_req), 0);
    chk("arst_faddr", 32'(a_faddr), 0);
    chk("arst_addr",  32'(a_addr), 0);
    chk("arst_level", 32'(a_level), 0);
    chk("arst_empty", 32'(a_empty), 1);
    chk("arst_top",   32'(a_top), 0);
    a_susp = 1'b1;
    tick(1);
    rst = 1'b0;
    a_fill = 1'b1;
    a_fdat = 8'h99;
    tick(1);
    a_fill = 1'b0;
    chk("arst_fill_level", 32'(a_level), 0);
    chk("arst_fill_empty", 32'(a_empty), 1);

    // 8086: odd start address, then word fetches, then POP during a 2-byte fill
    b_fq.push_back({1'b1, 16'h0100});
    b_fq.push_back({1'b0, 16'h0102});
    b_fq.push_back({1'b0, 16'h0104});
    b_flush = 1'b1;
    b_flush_addr = 16'h0101;
    b_susp = 1'b0;
    tick(1);
    b_flush = 1'b0;
    chk("b_flush_empty", 32'(b_empty), 1);
    chk("b_flush_addr",  32'(b_addr), 32'h0101);
    b_serve(16'hAA55, 1'b0, 1'b0);
    chk("b_odd_top",   32'(b_top), 32'hAA);
    chk("b_odd_addr",  32'(b_addr), 32'h0101);
    chk("b_odd_level", 32'(b_level), 1);
    b_serve(16'h2211, 1'b0, 1'b0);
    chk("b_word_level", 32'(b_level), 3);
    b_bq.push_back({8'hAA, 16'h0101});
    b_serve(16'h4433, 1'b1, 1'b1);
    chk("b_popfill_level", 32'(b_level), 4);
    chk("b_popfill_top",   32'(b_top), 32'h11);
    chk("b_popfill_addr",  32'(b_addr), 32'h0102);
    b_bq.push_back({8'h11, 16'h0102});
    b_bq.push_back({8'h22, 16'h0103});
    b_bq.push_back({8'h33, 16'h0104});
    b_bq.push_back({8'h44, 16'h0105});
    b_pop = 1'b1;
    tick(4);
    b_pop = 1'b0;
    chk("b_drain_empty", 32'(b_empty), 1);
    chk("b_drain_level", 32'(b_level), 0);
    chk("b_drain_addr",  32'(b_addr), 32'h0106);

    tick(3);
    chk("a_fetch_q_left", 32'(a_fq.size()), 0);
    chk("b_fetch_q_left", 32'(b_fq.size()), 0);
    chk("a_byte_q_left",  32'(a_bq.size()), 0);
    chk("b_byte_q_left",  32'(b_bq.size()), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/prefetch_queue_gen.md
# prefetch_queue_gen

Parametrised instruction prefetch queue for the 8088/8086 core family. It sits between the BIU bus sequencer and the EU, and generalises the fixed 4-byte, 8-bit-bus queue to configurable depth and bus width (1 or 2 bytes). It issues code-fetch requests whenever enough space is free, and absorbs returned bus data, including odd-address single-byte fills on a 16-bit bus. It presents the head byte and its CS offset to the EU, and discards in-flight fetches on flush.

## Interface
Parameters:
- BUS_BYTES, 1, bytes per fetch cycle: 1 for 8088 mode, 2 for 8086 mode; other values illegal
- DEPTH, 4, queue capacity in bytes, 4..16; must be a multiple of BUS_BYTES
- LW, $clog2(DEPTH+1), width of LEVEL

Ports:
- CORE_CLK  in  1  core clock; all state is updated on its rising edge
- RESET  in  1  asynchronous, active-high reset
- FLUSH  in  1  discard queue contents and restart fetching at FLUSH_ADDR
- FLUSH_ADDR  in  16  new IP (CS offset)
- SUSPEND  in  1  inhibits new fetch requests; does not affect a request already asserted
- FETCH_REQ  out  1  code fetch request
- FETCH_ADDR  out  16  bus offset of the fetch; word-aligned when BUS_BYTES=2
- FETCH_ODD  out  1  only the upper byte of the fill is valid (BUS_BYTES=2 only)
- FETCH_ACK  in  1  BIU accepts the request; bus cycle started
- FILL_VALID  in  1  fetch data returned
- FILL_DATA  in  8*BUS_BYTES  fetch data; byte 0 is at the lower address
- POP  in  1  EU consumes the head byte
- TOP_BYTE  out  8  head byte
- ADDR_OUT  out  16  CS offset of the head byte
- EMPTY  out  1  queue holds no bytes
- LEVEL  out  LW  number of bytes held

## Operation
- Storage is a circular buffer of DEPTH bytes with read pointer, write pointer, and count.
- A 16-bit fetch pointer FP holds the offset of the next byte to fetch.
- Fetch FSM states: IDLE, REQ, WAIT, DISCARD.
  - IDLE -> REQ when !SUSPEND && !FLUSH && free ≥ nbytes.
    - free = DEPTH - LEVEL.
    - nbytes = 1 if BUS_BYTES=2 && FP[0]=1, else BUS_BYTES.
  - REQ -> WAIT on FETCH_ACK. FETCH_ADDR, FETCH_ODD, and nbytes are frozen while the FSM is in REQ and WAIT.
  - WAIT -> IDLE on FILL_VALID. The valid bytes are written, FP advances by nbytes, and the count rises by nbytes.
  - DISCARD -> IDLE on FILL_VALID. Data is dropped and nothing is written.
- FETCH_ADDR = FP when BUS_BYTES=1; FP & 16'hFFFE when BUS_BYTES=2. FETCH_ODD = (BUS_BYTES=2) && FP[0].
- An odd fill writes only FILL_DATA[15:8].
- A 2-byte fill writes the low byte first, then the high byte.
- POP while not EMPTY advances the read pointer, increments ADDR_OUT, and decrements the count. POP while EMPTY is ignored.
- FLUSH in any state:
  - Count is set to 0 and pointers are reset.
  - FP and ADDR_OUT are loaded from FLUSH_ADDR.
  - Next state:
    - REQ without same-cycle FETCH_ACK -> IDLE.
    - REQ with same-cycle FETCH_ACK -> DISCARD.
    - WAIT without same-cycle FILL_VALID -> DISCARD.
    - WAIT with same-cycle FILL_VALID -> IDLE; the fill is dropped.
    - DISCARD -> DISCARD.
    - IDLE -> IDLE.
  - FLUSH beats any same-cycle POP or FILL_VALID.
- Same-cycle POP and fill (no FLUSH): both take effect. New count = count + nbytes - 1.
- The space check at IDLE->REQ is sufficient, because only one fetch is outstanding and POPs only increase free space.
- All 16-bit address arithmetic wraps modulo 2^16 (0xFFFF + 1 = 0x0000). No CS adjustment is made.

## Timing
- Reset values:
  - FSM=IDLE, count=0, FP=0, ADDR_OUT=0.
  - FETCH_REQ=0, FETCH_ADDR=0, FETCH_ODD=0.
  - EMPTY=1, LEVEL=0.
  - TOP_BYTE=0; storage is cleared.
- Reset asserted mid-operation returns everything to the reset values immediately. A fill arriving after reset release is ignored, because the FSM is in IDLE.
- FETCH_REQ is registered and high exactly while the FSM is in REQ. It is first high one cycle after the IDLE->REQ condition holds.
- Fill latency: on a FILL_VALID edge, the written bytes are visible on TOP_BYTE, EMPTY, and LEVEL in the next cycle.
- TOP_BYTE and ADDR_OUT are combinational from storage at the read pointer. After a POP edge they show the next byte in the same cycle as the updated count.
- After a FLUSH edge, EMPTY=1 and ADDR_OUT=FLUSH_ADDR in the next cycle. The earliest FETCH_REQ is one cycle after that, from IDLE.
- Back-to-back fetches: FILL_VALID (WAIT->IDLE), then IDLE->REQ in the following cycle, giving a minimum 2-cycle gap between FILL_VALID and the next FETCH_REQ.

## Structure
- Shared package pfq_pkg:
  - fetch FSM state enum (IDLE, REQ, WAIT, DISCARD)
  - BUS_BYTES legality constants
  - function computing nbytes from BUS_BYTES and FP[0]
- Sub-module pfq_store: DEPTH-byte circular buffer with a 1- or 2-byte write port and a 1-byte read port. It owns the read/write pointers and the count.
- The top level holds the FSM, FP, ADDR_OUT, and the flush logic.

## Test plan
- Reset/fill with BUS_BYTES=1, DEPTH=4, no POP: exactly 4 fetches at 0x0000..0x0003. LEVEL=4. FETCH_REQ stays low while full. One POP lets the 5th request go to 0x0004.
- BUS_BYTES=2, DEPTH=6, FLUSH_ADDR=0x0101:
  - First fetch: FETCH_ADDR=0x0100, FETCH_ODD=1. Fill 0xAA55 leaves TOP_BYTE=0xAA, ADDR_OUT=0x0101, LEVEL=1.
  - Next fetch: 0x0102, FETCH_ODD=0.
- FLUSH to 0x2000 while in WAIT: the following FILL_VALID is dropped and LEVEL stays 0. The next FETCH_ADDR is 0x2000.
- Same-cycle POP and 2-byte fill at LEVEL=3: LEVEL becomes 4. TOP_BYTE shows the old second byte, then the fill bytes appear in order.
- FLUSH_ADDR=0xFFFF with BUS_BYTES=1: fetches go to 0xFFFF, then 0x0000. Popping both bytes gives ADDR_OUT sequence 0xFFFF, 0x0000, 0x0001.
- Asynchronous RESET pulse mid-WAIT: all outputs return to reset values without a clock edge, and a later FILL_VALID causes no write.
